chacha_keystream_xor: RTL

- Consumer end of the ChaCha state path: accepts finished 4x4 keystream blocks (post-rounds, post-add, same row/col layout as the state-matrix builder output) and XORs them word-by-word onto a 32-bit plaintext/ciphertext stream.
- Owns the block counter fed back to the state builder's Block input.
- Sits between the round core output and the AEAD data path; encrypt and decrypt are identical.

---
 rtl/chacha_keystream_xor_pkg.sv | 25 ++
 rtl/chacha_keystream_xor_ks_byte_mask.sv | 22 ++
 rtl/chacha_keystream_xor.sv | 118 +++++++++++
 3 files changed

// File: rtl/chacha_keystream_xor_pkg.sv
// Shared ChaCha types: 32-bit word, 4x4 state matrix, FSM states and the RFC 8439 constant row.
package chacha_keystream_xor_pkg;

  localparam int CHACHA_WORDS = 16;
  localparam int IDX_W        = $clog2(CHACHA_WORDS);

  typedef logic [31:0] word_t;
  typedef word_t [3:0][3:0] chacha_state_t;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  // Row 0 of the initial state: "expand 32-byte k" as little-endian words.
  function automatic word_t chacha_const(input logic [1:0] col);
    case (col)
      2'd0:    return 32'h61707865;
      2'd1:    return 32'h3320646e;
      2'd2:    return 32'h79622d32;
      default: return 32'h6b206574;
    endcase
  endfunction

endpackage

// File: rtl/chacha_keystream_xor_ks_byte_mask.sv
// Turns the final-word byte count into a lane mask; out-of-range counts mean a full word.
module chacha_keystream_xor_ks_byte_mask (
  input  logic [2:0]  in_bytes,
  input  logic        in_last,
  output logic [31:0] mask,
  output logic [2:0]  bytes
);

  always_comb begin
    mask  = '1;
    bytes = 3'd4;
    if (in_last) begin
      case (in_bytes)
        3'd1: begin mask = 32'h0000_00ff; bytes = 3'd1; end
        3'd2: begin mask = 32'h0000_ffff; bytes = 3'd2; end
        3'd3: begin mask = 32'h00ff_ffff; bytes = 3'd3; end
        default: begin mask = '1; bytes = 3'd4; end
      endcase
    end
  end

endmodule

// File: rtl/chacha_keystream_xor.sv
// Consumes finished ChaCha keystream blocks and XORs them word-by-word onto a 32-bit data
// stream; owns the block counter fed back to the state builder.
module chacha_keystream_xor
  import chacha_keystream_xor_pkg::*;
#(
  parameter logic [31:0] COUNTER_INIT = 32'd1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          blk_valid,
  output logic          blk_ready,
  input  chacha_state_t blk_state,
  output logic [31:0]   blk_count,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   in_data,
  input  logic          in_last,
  input  logic [2:0]    in_bytes,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_last,
  output logic [2:0]    out_bytes,
  output logic          ctr_wrap
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHACHA_WORDS - 1);

  state_t           state, state_next;
  logic [IDX_W-1:0] word_idx;
  chacha_state_t    ks;
  word_t            ks_word;
  logic             accept;
  logic [31:0]      mask;
  logic [2:0]       bytes_eff;

  logic             vld_p1;
  logic [31:0]      data_p1;
  logic             last_p1;
  logic [2:0]       bytes_p1;

  chacha_keystream_xor_ks_byte_mask u_mask (
    .in_bytes (in_bytes),
    .in_last  (in_last),
    .mask     (mask),
    .bytes    (bytes_eff)
  );

  // Row-major serialization: word k comes from row k/4, column k%4.
  assign ks_word = ks[word_idx[3:2]][word_idx[1:0]];
  assign accept  = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    blk_ready  = 1'b0;
    in_ready   = 1'b0;
    case (state)
      IDLE: begin
        blk_ready = 1'b1;
        if (blk_valid) state_next = STREAM;
      end
      STREAM: begin
        in_ready = !vld_p1 || out_ready;
        if (in_valid && (!vld_p1 || out_ready) && (in_last || word_idx == LAST_IDX))
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Stage p0 -> p1: one-entry output register, accept and drain may coincide.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_idx  <= '0;
      blk_count <= COUNTER_INIT;
      ctr_wrap  <= 1'b0;
      ks        <= '0;
      vld_p1    <= 1'b0;
      data_p1   <= '0;
      last_p1   <= 1'b0;
      bytes_p1  <= 3'd4;
    end else begin
      if (blk_valid && blk_ready) begin
        ks       <= blk_state;
        word_idx <= '0;
      end
      if (accept) begin
        vld_p1   <= 1'b1;
        data_p1  <= (in_data ^ ks_word) & mask;
        last_p1  <= in_last;
        bytes_p1 <= bytes_eff;
        if (in_last) begin
          word_idx  <= '0;
          blk_count <= COUNTER_INIT;
        end else if (word_idx == LAST_IDX) begin
          word_idx  <= '0;
          blk_count <= blk_count + 32'd1;
          if (blk_count == 32'hFFFF_FFFF) ctr_wrap <= 1'b1;
        end else begin
          word_idx <= word_idx + IDX_W'(1);
        end
      end else if (out_ready) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  assign out_valid = vld_p1;
  assign out_data  = data_p1;
  assign out_last  = last_p1;
  assign out_bytes = bytes_p1;

endmodule
